// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field widths, packing helpers and
// the state codes of the sequential divider.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int QUOT_W = 26;

  localparam logic [EXP_W-1:0] BIAS    = 8'd127;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  localparam logic [1:0] FDIV_IDLE  = 2'd0;
  localparam logic [1:0] FDIV_DIV   = 2'd1;
  localparam logic [1:0] FDIV_ROUND = 2'd2;
  localparam logic [1:0] FDIV_DONE  = 2'd3;

  function automatic fp32_t fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                    input logic [FRAC_W-1:0] f);
    fp32_t r;
    r.sign = s;
    r.exp  = e;
    r.frac = f;
    return r;
  endfunction

  function automatic fp32_t fp_inf(input logic s);
    return fp_pack(s, EXP_INF, 23'h0);
  endfunction

  function automatic fp32_t fp_zero(input logic s);
    return fp_pack(s, 8'h00, 23'h0);
  endfunction

  // Significand with the hidden one restored (denormals are never seen here).
  function automatic logic [MANT_W-1:0] fp_mant(input fp32_t v);
    return {1'b1, v.frac};
  endfunction

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module fdiv_step
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [MANT_W-1:0] m2,
  output logic [MANT_W-1:0] rem_out,
  output logic              qbit
);

  logic [MANT_W:0] shifted_s;
  logic [MANT_W:0] diff_s;

  // Compare-and-subtract; the remainder always stays below m2, so MANT_W bits suffice.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {1'b0, m2};
    if (shifted_s >= {1'b0, m2}) begin
      qbit    = 1'b1;
      rem_out = diff_s[MANT_W-1:0];
    end else begin
      qbit    = 1'b0;
      rem_out = shifted_s[MANT_W-1:0];
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle single-precision divider y = x1 / x2 with valid/ready handshakes,
// restoring mantissa division and round-to-nearest-even.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);

  localparam logic [4:0] DIV_LAST = 5'(QUOT_W / BITS_PER_CYCLE - 1);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bpc
    $error("fdiv_seq: BITS_PER_CYCLE must be 1 or 2");
  end

  fp32_t a_s;
  fp32_t b_s;
  logic  a_exp_zero_s;
  logic  b_exp_zero_s;

  assign a_s          = x1;
  assign b_s          = x2;
  assign a_exp_zero_s = (a_s.exp == 8'h00);
  assign b_exp_zero_s = (b_s.exp == 8'h00);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;
  logic [31:0]       y_r;
  logic              sign_r;
  logic [EXP_W-1:0]  e1_r;
  logic [EXP_W-1:0]  e2_r;
  logic [MANT_W-1:0] m2_r;
  logic [MANT_W-1:0] rem_r;
  logic [QUOT_W-1:0] q_r;
  logic [4:0]        cnt_r;
  logic              m1_lsb_r;
  logic              div0_r;
  logic              zero_r;

  // The remainder starts as m1>>1 so that the first step shifts in m1[0] and
  // yields q[25] = floor(m1/m2); every later step shifts in a zero.
  logic              first_bit_s;
  logic [MANT_W-1:0] rem0_s;
  logic              qbit0_s;
  logic [MANT_W-1:0] rem_step_s;
  logic [QUOT_W-1:0] q_step_s;

  assign first_bit_s = (cnt_r == 5'd0) ? m1_lsb_r : 1'b0;

  fdiv_step u_step0 (
    .rem_in (rem_r),
    .bit_in (first_bit_s),
    .m2     (m2_r),
    .rem_out(rem0_s),
    .qbit   (qbit0_s)
  );

  if (BITS_PER_CYCLE == 2) begin : g_two
    logic [MANT_W-1:0] rem1_s;
    logic              qbit1_s;

    fdiv_step u_step1 (
      .rem_in (rem0_s),
      .bit_in (1'b0),
      .m2     (m2_r),
      .rem_out(rem1_s),
      .qbit   (qbit1_s)
    );

    assign rem_step_s = rem1_s;
    assign q_step_s   = {q_r[QUOT_W-3:0], qbit0_s, qbit1_s};
  end else begin : g_one
    assign rem_step_s = rem0_s;
    assign q_step_s   = {q_r[QUOT_W-2:0], qbit0_s};
  end

  logic [FRAC_W-1:0] mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic              inc_s;
  logic [FRAC_W:0]   mant_rnd_s;
  logic signed [9:0] exp_diff_s;
  logic signed [9:0] exp_pre_s;
  logic signed [9:0] exp_fin_s;
  fp32_t             y_calc_s;

  // Normalise, round to nearest even and apply the special/range overrides.
  always_comb begin
    exp_diff_s = $signed({2'b00, e1_r}) - $signed({2'b00, e2_r}) + $signed({2'b00, BIAS});
    if (q_r[QUOT_W-1]) begin
      mant_s    = q_r[24:2];
      guard_s   = q_r[1];
      sticky_s  = q_r[0] | (|rem_r);
      exp_pre_s = exp_diff_s;
    end else begin
      mant_s    = q_r[23:1];
      guard_s   = q_r[0];
      sticky_s  = |rem_r;
      exp_pre_s = exp_diff_s - 10'sd1;
    end
    inc_s      = guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {{FRAC_W{1'b0}}, inc_s};
    if (mant_rnd_s[FRAC_W]) begin
      exp_fin_s = exp_pre_s + 10'sd1;
    end else begin
      exp_fin_s = exp_pre_s;
    end
    if (div0_r) begin
      y_calc_s = fp_inf(sign_r);
    end else if (zero_r) begin
      y_calc_s = fp_zero(sign_r);
    end else if (exp_fin_s <= 10'sd0) begin
      y_calc_s = fp_zero(sign_r);
    end else if (exp_fin_s >= 10'sd255) begin
      y_calc_s = fp_inf(sign_r);
    end else begin
      y_calc_s = fp_pack(sign_r, exp_fin_s[7:0], mant_rnd_s[FRAC_W-1:0]);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FDIV_IDLE: begin
        if (in_valid) begin
          state_nxt_s = (a_exp_zero_s | b_exp_zero_s) ? FDIV_ROUND : FDIV_DIV;
        end else begin
          state_nxt_s = FDIV_IDLE;
        end
      end
      FDIV_DIV: begin
        if (cnt_r == DIV_LAST) begin
          state_nxt_s = FDIV_ROUND;
        end else begin
          state_nxt_s = FDIV_DIV;
        end
      end
      FDIV_ROUND: state_nxt_s = FDIV_DONE;
      FDIV_DONE: begin
        if (out_ready) begin
          state_nxt_s = FDIV_IDLE;
        end else begin
          state_nxt_s = FDIV_DONE;
        end
      end
      default: state_nxt_s = FDIV_IDLE;
    endcase
  end

  // State register with in_ready/busy registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= FDIV_IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == FDIV_IDLE);
      busy_r     <= (state_nxt_s != FDIV_IDLE);
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      y_r         <= 32'h0;
      sign_r      <= 1'b0;
      e1_r        <= 8'h00;
      e2_r        <= 8'h00;
      m2_r        <= 24'h0;
      rem_r       <= 24'h0;
      q_r         <= 26'h0;
      cnt_r       <= 5'd0;
      m1_lsb_r    <= 1'b0;
      div0_r      <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        FDIV_IDLE: begin
          if (in_valid) begin
            sign_r   <= a_s.sign ^ b_s.sign;
            e1_r     <= a_s.exp;
            e2_r     <= b_s.exp;
            m2_r     <= fp_mant(b_s);
            rem_r    <= {2'b01, a_s.frac[22:1]};
            m1_lsb_r <= a_s.frac[0];
            q_r      <= 26'h0;
            cnt_r    <= 5'd0;
            div0_r   <= b_exp_zero_s;
            zero_r   <= a_exp_zero_s;
          end
        end
        FDIV_DIV: begin
          rem_r <= rem_step_s;
          q_r   <= q_step_s;
          cnt_r <= cnt_r + 5'd1;
        end
        FDIV_ROUND: begin
          y_r         <= y_calc_s;
          out_valid_r <= 1'b1;
        end
        FDIV_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: table of hand-computed quotients on one- and
// two-bit-per-cycle instances, plus backpressure and mid-operation reset.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid_a, in_valid_b, out_ready;
  logic [31:0] x1, x2;
  logic        in_ready_a, out_valid_a, busy_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [31:0] y_a, y_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fdiv_seq #(.BITS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .x1(x1), .x2(x2), .out_valid(out_valid_a), .out_ready(out_ready),
    .y(y_a), .busy(busy_a)
  );

  fdiv_seq #(.BITS_PER_CYCLE(2)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x1(x1), .x2(x2), .out_valid(out_valid_b), .out_ready(out_ready),
    .y(y_b), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    bit          special;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  function automatic logic sel_ov(input int sel);
    return (sel == 0) ? out_valid_a : out_valid_b;
  endfunction

  function automatic logic [31:0] sel_y(input int sel);
    return (sel == 0) ? y_a : y_b;
  endfunction

  function automatic logic [31:0] sel_flags(input int sel);
    if (sel == 0) return {29'd0, in_ready_a, out_valid_a, busy_a};
    else          return {29'd0, in_ready_b, out_valid_b, busy_b};
  endfunction

  // Present one operand pair; lat counts cycles from the accept cycle to out_valid.
  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    x1 = a;
    x2 = b;
    if (sel == 0) in_valid_a = 1'b1;
    else          in_valid_b = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    x1 = $urandom();
    x2 = $urandom();
    lat = 1;
    while (!sel_ov(sel) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = sel_y(sel);
  endtask

  task automatic run_vec(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input bit special, input string name);
    logic [31:0] res;
    int          lat;
    int          want_lat;
    want_lat = special ? 2 : ((sel == 0) ? 28 : 15);
    check($sformatf("%s_idle", name), sel_flags(sel), 32'd4);
    do_op(sel, a, b, res, lat);
    check($sformatf("%s_y", name), res, want);
    check($sformatf("%s_lat", name), 32'(lat), 32'(want_lat));
    @(posedge clk);
    #1;
    check($sformatf("%s_release", name), sel_flags(sel), 32'd4);
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int          lat;

    rstn = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    out_ready = 1'b1;
    x1 = 32'h0;
    x2 = 32'h0;
    #1 rstn = 1'b0;
    #21;
    check("rst_a_flags", sel_flags(0), 32'd4);
    check("rst_a_y", y_a, 32'h0);
    check("rst_b_flags", sel_flags(1), 32'd4);
    check("rst_b_y", y_b, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
    vecs[2]  = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1};
    vecs[4]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b1};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 1'b0};
    vecs[8]  = '{32'hC0C00000, 32'hC0000000, 32'h40400000, 1'b0};
    vecs[9]  = '{32'h40C00000, 32'hC0000000, 32'hC0400000, 1'b0};
    vecs[10] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 1'b0};
    vecs[11] = '{32'h80000000, 32'h00000000, 32'hFF800000, 1'b1};
    vecs[12] = '{32'h41200000, 32'h40A00000, 32'h40000000, 1'b0};

    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 13; i++) begin
        run_vec(sel, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].special,
                $sformatf("b%0d_v%0d", sel + 1, i));
      end
    end

    // Backpressure: result held for 10 cycles while a new request is ignored.
    out_ready = 1'b0;
    do_op(0, 32'h40C00000, 32'h40000000, res, lat);
    check("bp_y", res, 32'h40400000);
    check("bp_lat", 32'(lat), 32'd28);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid_a = 1'b1;
      x1 = 32'h3F800000;
      x2 = 32'h40400000;
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_y", k), y_a, 32'h40400000);
      check($sformatf("bp_hold%0d_flags", k), sel_flags(0), 32'd3);
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", sel_flags(0), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_single", sel_flags(0), 32'd4);

    // Reset in the middle of DIV aborts the operation.
    @(negedge clk);
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    check("rst_mid_busy", sel_flags(0), 32'd1);
    repeat (9) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_mid_flags", sel_flags(0), 32'd4);
    check("rst_mid_y", y_a, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("rst_no_output", sel_flags(0), 32'd4);
    run_vec(0, 32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, "rst_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Multi-cycle IEEE-754 single-precision divider y = x1 / x2; the inverse operation of the FPU's multiplier.
- Iterative restoring mantissa division, BITS_PER_CYCLE quotient bits per clock.
- valid/ready handshake on input and output so the core pipeline can stall on it.
- Simplified FPU conventions: no denormals (flush-to-zero), round-to-nearest-even, Inf/NaN inputs unsupported.

Parameters:
- BITS_PER_CYCLE, 1: quotient bits retired per clock. Legal values are 1 and 2; elaboration error otherwise.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- x1  input  32  dividend
- x2  input  32  divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- y  output  32  quotient
- busy  output  1  division in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, busy=0, all datapath registers 0.
- Reset mid-operation aborts the division immediately; no output is produced.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch sign=x1[31]^x2[31], e1, e2, m1={1,x1[22:0]}, m2={1,x2[22:0]}. Next state is DIV, or ROUND directly for special cases.
  - DIV: runs 26/BITS_PER_CYCLE cycles (26 or 13). Each step: rem={rem,bit}; if rem>=m2 then rem-=m2 and q-bit=1. Result is q = floor(m1*2^25/m2), 26 bits. Then go to ROUND.
  - ROUND: normalise, round and pack into y. Set out_valid=1 and go to DONE.
  - DONE: hold y and out_valid while out_ready=0. On out_ready, clear out_valid and go to IDLE. The next input is accepted no earlier than the following cycle.
- Latency: acceptance to out_valid = 26/BITS_PER_CYCLE + 2 cycles (28 for B=1, 15 for B=2). Throughput is one operation in flight.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored, and operands need not stay stable after acceptance.
- Normalisation:
  - q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(rem!=0), exp=e1-e2+127.
  - q[25]=0: mant=q[23:1], guard=q[0], sticky=(rem!=0), exp=e1-e2+126.
- Exponent is computed as a signed 10-bit value.
- Rounding (RNE): increment mant if guard & (sticky | mant[0]). On mantissa carry-out, mant=0 and exp+=1.
- Specials and limits, in priority order:
  1. x2 exponent field == 0: y = {sign, 8'hFF, 23'h0}.
  2. x1 exponent field == 0: y = {sign, 31'h0}.
  3. exp <= 0 after rounding: y = {sign, 31'h0}.
  4. exp >= 255: y = {sign, 8'hFF, 23'h0}.
- Specials skip DIV, so their latency is 2 cycles.
- Exponent field 255 on an input: result is unspecified, but the FSM must complete and return to IDLE normally.

Decomposition:
- fpu_pkg (shared with the rest of the FPU):
  - widths: EXP_W=8, FRAC_W=23, MANT_W=24
  - BIAS=127, EXP_INF=8'hFF
  - typedef fp32_t as a packed struct {sign, exp, frac}
  - state enum for this block
- fdiv_step: one combinational sub-module for a single restoring iteration (rem_in, m2 -> rem_out, qbit). It is instantiated BITS_PER_CYCLE times, chained.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> y=0x40400000; out_valid exactly 28 cycles after acceptance (B=1) and 15 cycles (B=2).
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, exercising round-up. Also 0xBF800000 / 0x40400000 -> 0xBEAAAAAB.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000
  - 0x80000000 / 0x40000000 -> 0x80000000
  - both after 2 cycles
- Range limits:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow)
  - 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush)
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. y is stable, in_ready=0, and a new in_valid is ignored. Release: exactly one result is consumed, then in_ready=1.
- Reset: assert rstn=0 at DIV cycle 10. All outputs go to reset values asynchronously. The next operation 0x41200000 / 0x40A00000 (10/5) -> 0x40000000 with the correct result and latency.
